// File: rtl/i_cache_assoc.sv
// Two-way set-associative instruction cache with per-set LRU and word-by-word bus refill.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module i_cache_assoc #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int LW        = 1 << (OFFSET_WIDTH - 2);
  localparam int WORD_W    = (OFFSET_WIDTH > 2) ? (OFFSET_WIDTH - 2) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [WORD_W-1:0]      cnt_q, cnt_d;
  logic                   victim_q, victim_d;
  logic                   wait_data_q, wait_data_d;
  logic [1:0][SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]        lru_q, lru_d;

  logic [TAG_WIDTH-1:0]   tag_mem  [2][SETS];
  logic [31:0]            data_mem [2][SETS][LW];

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_W-1:0]      req_word;
  logic                   hit0, hit1, hit, hit_way;
  logic [31:0]            hit_data;
  logic                   victim_sel;
  logic                   data_we, fill_done;
  logic [31:0]            refill_addr;
  logic                   unused_inputs;

  assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

  assign req_tag   = cpu_inst_addr[31 -: TAG_WIDTH];
  assign req_index = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word  = WORD_W'((cpu_inst_addr >> 2) & 32'(LW - 1));

  assign hit0     = valid_q[0][req_index] && (tag_mem[0][req_index] == req_tag);
  assign hit1     = valid_q[1][req_index] && (tag_mem[1][req_index] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_data = hit0 ? data_mem[0][req_index][req_word] : data_mem[1][req_index][req_word];

  // Prefer an empty way before evicting the least recently used one.
  assign victim_sel = !valid_q[0][req_index] ? 1'b0 :
                      !valid_q[1][req_index] ? 1'b1 : lru_q[req_index];

  assign data_we     = (state_q == REFILL) && wait_data_q && cache_inst_data_ok;
  assign fill_done   = data_we && (cnt_q == WORD_W'(LW - 1));
  assign refill_addr = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}} | (32'(cnt_q) << 2);

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_wdata = 32'd0;
  assign cache_inst_size  = {resetn, 1'b0};

  always_comb begin
    state_d          = state_q;
    tag_d            = tag_q;
    index_d          = index_q;
    word_d           = word_q;
    cnt_d            = cnt_q;
    victim_d         = victim_q;
    wait_data_d      = wait_data_q;
    valid_d          = valid_q;
    lru_d            = lru_q;
    cpu_inst_rdata   = 32'd0;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cache_inst_req   = 1'b0;
    cache_inst_addr  = 32'd0;
    case (state_q)
      IDLE: begin
        if (cpu_inst_req) begin
          if (hit) begin
            cpu_inst_addr_ok      = 1'b1;
            cpu_inst_data_ok      = 1'b1;
            cpu_inst_rdata        = hit_data;
            lru_d[req_index]      = ~hit_way;
          end else begin
            tag_d                 = req_tag;
            index_d               = req_index;
            word_d                = req_word;
            victim_d              = victim_sel;
            valid_d[victim_sel][req_index] = 1'b0;
            cnt_d                 = '0;
            wait_data_d           = 1'b0;
            state_d               = REFILL;
          end
        end
      end
      REFILL: begin
        cache_inst_req  = ~wait_data_q;
        cache_inst_addr = refill_addr;
        if (!wait_data_q && cache_inst_addr_ok) begin
          wait_data_d = 1'b1;
        end
        // Only one read is ever outstanding, so each data_ok belongs to word cnt.
        if (data_we) begin
          wait_data_d = 1'b0;
          cnt_d       = cnt_q + WORD_W'(1);
          if (fill_done) begin
            valid_d[victim_q][index_q] = 1'b1;
            lru_d[index_q]             = ~victim_q;
            state_d                    = DONE;
          end
        end
      end
      DONE: begin
        cpu_inst_addr_ok = 1'b1;
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = data_mem[victim_q][index_q][word_q];
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      wait_data_q <= 1'b0;
      valid_q     <= '0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      victim_q    <= victim_d;
      wait_data_q <= wait_data_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
    end
  end

  // Line storage needs no reset: valid bits gate every read.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[victim_q][index_q][cnt_q] <= cache_inst_rdata;
    end
    if (fill_done) begin
      tag_mem[victim_q][index_q] <= tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && cpu_inst_req) begin
      if (hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed bench for i_cache_assoc: cold refill, LRU replacement, slow bus, reset mid-refill.
// Expects statistics values matching whether ICACHE_STATS_EN is defined.
module tb_i_cache_assoc;

  localparam int LW = 4;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_inst_req = 1'b0;
  logic        cpu_inst_wr = 1'b0;
  logic [1:0]  cpu_inst_size = 2'b10;
  logic [31:0] cpu_inst_addr = 32'd0;
  logic [31:0] cpu_inst_wdata = 32'd0;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic        cache_inst_req, cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr, cache_inst_wdata;
  logic [31:0] cache_inst_rdata = 32'd0;
  logic        cache_inst_addr_ok = 1'b0;
  logic        cache_inst_data_ok = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int addr_delay = 0;
  int data_delay = 0;
  int data_count = 0;
  logic [31:0] grant_log[$];

  i_cache_assoc dut (
    .clk(clk), .resetn(resetn),
    .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr), .cpu_inst_size(cpu_inst_size),
    .cpu_inst_addr(cpu_inst_addr), .cpu_inst_wdata(cpu_inst_wdata),
    .cpu_inst_rdata(cpu_inst_rdata), .cpu_inst_addr_ok(cpu_inst_addr_ok),
    .cpu_inst_data_ok(cpu_inst_data_ok),
    .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr),
    .cache_inst_size(cache_inst_size), .cache_inst_addr(cache_inst_addr),
    .cache_inst_wdata(cache_inst_wdata), .cache_inst_rdata(cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok), .cache_inst_data_ok(cache_inst_data_ok),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus slave: one outstanding read, programmable addr_ok and data_ok delays.
  initial begin
    int phase;
    int wait_cnt;
    logic [31:0] pend_addr;
    phase = 0;
    wait_cnt = 0;
    pend_addr = 32'd0;
    forever begin
      @(negedge clk);
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      if (!resetn) begin
        phase = 0;
        wait_cnt = 0;
      end else if (phase == 0) begin
        if (cache_inst_req) begin
          if (wait_cnt >= addr_delay) begin
            cache_inst_addr_ok = 1'b1;
            pend_addr = cache_inst_addr;
            grant_log.push_back(cache_inst_addr);
            phase = 1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        if (wait_cnt >= data_delay) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata = mem_word(pend_addr);
          data_count++;
          phase = 0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, output logic [31:0] data, output int lat,
                               output int grants, output int datas);
    int g0;
    int d0;
    bit got;
    g0 = grant_log.size();
    d0 = data_count;
    data = 32'd0;
    lat = 0;
    grants = 0;
    datas = 0;
    got = 1'b0;
    @(negedge clk);
    cpu_inst_req = 1'b1;
    cpu_inst_addr = a;
    #1;
    while (!got && lat < 500) begin
      if (cpu_inst_data_ok) begin
        got = 1'b1;
        data = cpu_inst_rdata;
        grants = grant_log.size() - g0;
        datas = data_count - d0;
        checkOutput("addr_ok_with_data_ok", {31'd0, cpu_inst_addr_ok}, 32'd1);
      end else begin
        @(negedge clk);
        #1;
        lat++;
      end
    end
    checkOutput("fetch_completed", {31'd0, got}, 32'd1);
    @(negedge clk);
    cpu_inst_req = 1'b0;
  endtask

  task automatic checkRefill(input string tag, input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    checkOutput({tag, "_grants"}, 32'(grant_log.size()), 32'(LW));
    for (int i = 0; i < LW && i < grant_log.size(); i++) begin
      checkOutput({tag, "_addr"}, grant_log[i], base + 32'(4 * i));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    cpu_inst_req = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int lat, g, dc;
    bit cond;
    int d0;

    $display("[TB] start");
    cpu_inst_req = 1'b1;
    cpu_inst_addr = 32'hBFC0_0008;
    #2;
    checkOutput("rst_cpu_addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd0);
    checkOutput("rst_cpu_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_inst_rdata, 32'd0);
    checkOutput("rst_cache_req", {31'd0, cache_inst_req}, 32'd0);
    checkOutput("rst_cache_size", {30'd0, cache_inst_size}, 32'd0);
    checkOutput("rst_cache_addr", cache_inst_addr, 32'd0);
    checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
    checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
    doReset();

    grant_log.delete();
    applyStimulus(32'hBFC0_0008, d, lat, g, dc);
    checkOutput("cold_rdata", d, mem_word(32'hBFC0_0008));
    checkOutput("cold_is_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("cold_data_before_hs", 32'(dc), 32'(LW));
    checkRefill("cold", 32'hBFC0_0008);
    applyStimulus(32'hBFC0_000C, d, lat, g, dc);
    checkOutput("warm_rdata", d, mem_word(32'hBFC0_000C));
    checkOutput("warm_latency", 32'(lat), 32'd0);
    checkOutput("warm_no_bus", 32'(g), 32'd0);

    doReset();
    applyStimulus(32'h0000_0000, d, lat, g, dc);
    checkOutput("A_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("A_rdata", d, mem_word(32'h0000_0000));
    applyStimulus(32'h0000_4000, d, lat, g, dc);
    checkOutput("B_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("B_rdata", d, mem_word(32'h0000_4000));
    applyStimulus(32'h0000_0000, d, lat, g, dc);
    checkOutput("A_rehit_latency", 32'(lat), 32'd0);
    checkOutput("A_rehit_rdata", d, mem_word(32'h0000_0000));
    checkOutput("hit_cnt_after_A", hit_cnt, STATS ? 32'd1 : 32'd0);
    applyStimulus(32'h0000_8000, d, lat, g, dc);
    checkOutput("C_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("C_rdata", d, mem_word(32'h0000_8000));
    checkOutput("miss_cnt_after_C", miss_cnt, STATS ? 32'd3 : 32'd0);
    checkOutput("hit_cnt_after_C", hit_cnt, STATS ? 32'd1 : 32'd0);
    applyStimulus(32'h0000_0000, d, lat, g, dc);
    checkOutput("A_kept_latency", 32'(lat), 32'd0);
    applyStimulus(32'h0000_4000, d, lat, g, dc);
    checkOutput("B_evicted_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("B_refetch_rdata", d, mem_word(32'h0000_4000));
    applyStimulus(32'h0000_0000, d, lat, g, dc);
    checkOutput("A_still_hits", 32'(lat), 32'd0);

    addr_delay = 3;
    data_delay = 5;
    grant_log.delete();
    applyStimulus(32'h1234_5678, d, lat, g, dc);
    checkOutput("slow_rdata", d, mem_word(32'h1234_5678));
    checkOutput("slow_grants_before_hs", 32'(g), 32'(LW));
    checkOutput("slow_data_before_hs", 32'(dc), 32'(LW));
    checkRefill("slow", 32'h1234_5678);

    data_delay = 2;
    grant_log.delete();
    d0 = data_count;
    @(negedge clk);
    cpu_inst_req = 1'b1;
    cpu_inst_addr = 32'h0000_1230;
    cond = 1'b0;
    for (int i = 0; i < 200 && !cond; i++) begin
      @(negedge clk);
      #1;
      cond = (data_count - d0 == 1) && cache_inst_req;
    end
    checkOutput("second_word_reached", {31'd0, cond}, 32'd1);
    checkOutput("refill_addr_word1", cache_inst_addr, 32'h0000_1234);
    checkOutput("refill_wr", {31'd0, cache_inst_wr}, 32'd0);
    checkOutput("refill_size", {30'd0, cache_inst_size}, 32'd2);
    checkOutput("refill_wdata", cache_inst_wdata, 32'd0);
    checkOutput("refill_no_cpu_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_req_drop", {31'd0, cache_inst_req}, 32'd0);
    checkOutput("midrst_addr", cache_inst_addr, 32'd0);
    checkOutput("midrst_miss_cnt", miss_cnt, 32'd0);
    cpu_inst_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    grant_log.delete();
    applyStimulus(32'h0000_1230, d, lat, g, dc);
    checkOutput("postrst_miss", {31'd0, lat > 0}, 32'd1);
    checkOutput("postrst_rdata", d, mem_word(32'h0000_1230));
    checkRefill("postrst", 32'h0000_1230);
    checkOutput("postrst_miss_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i_cache_assoc.md
I_CACHE_ASSOC -- requirements
Module: i_cache_assoc

Interface
REQ-001 SHALL provide parameter INDEX_WIDTH, default 7, set-index bits (sets = 2^INDEX_WIDTH).
REQ-002 SHALL provide parameter OFFSET_WIDTH, default 4, byte-offset bits (line words LW = 2^(OFFSET_WIDTH-2), OFFSET_WIDTH >= 2).
REQ-003 SHALL derive TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH; ways fixed at 2.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cpu_inst_req in 1, cpu_inst_wr in 1, cpu_inst_size in 2, cpu_inst_addr in 32, cpu_inst_wdata in 32: core fetch request.
REQ-007 SHALL have ports cpu_inst_rdata out 32, cpu_inst_addr_ok out 1, cpu_inst_data_ok out 1: core response.
REQ-008 SHALL have ports cache_inst_req out 1, cache_inst_wr out 1, cache_inst_size out 2, cache_inst_addr out 32, cache_inst_wdata out 32: bus request.
REQ-009 SHALL have ports cache_inst_rdata in 32, cache_inst_addr_ok in 1, cache_inst_data_ok in 1: bus response.
REQ-010 SHALL have ports hit_cnt out 32, miss_cnt out 32: statistics.

Function
REQ-011 SHALL store per set and way: valid, tag, LW data words; plus one LRU bit per set (names the way to replace).
REQ-012 SHALL decode addr as tag=[31:INDEX_WIDTH+OFFSET_WIDTH], index=next INDEX_WIDTH bits, word=[OFFSET_WIDTH-1:2].
REQ-013 SHALL have states IDLE, REFILL, DONE.
REQ-014 In IDLE with cpu_inst_req and hit in either way, SHALL assert cpu_inst_addr_ok and cpu_inst_data_ok combinationally same cycle, rdata = hit word; LRU set to other way at the edge.
REQ-015 Both ways hitting (impossible by construction) SHALL resolve to way 0.
REQ-016 In IDLE with cpu_inst_req and miss, SHALL latch tag/index/word, select victim (invalid way 0, else invalid way 1, else LRU way), enter REFILL, word counter = 0.
REQ-017 In REFILL SHALL issue LW single-word reads, addr = {tag,index,cnt,2'b00}, cnt 0..LW-1 ascending; cache_inst_req high until addr_ok accepted, then low until data_ok; at most one outstanding.
REQ-018 Each data_ok SHALL write cache_inst_rdata into victim word cnt, increment cnt; on last word set victim valid, write tag, set LRU to other way, enter DONE.
REQ-019 Victim valid SHALL be cleared on entering REFILL so partial lines never hit.
REQ-020 In DONE SHALL assert cpu_inst_addr_ok and cpu_inst_data_ok for one cycle with rdata = latched word, then return to IDLE.
REQ-021 No cpu handshake SHALL be asserted in REFILL; core holds addr stable.
REQ-022 cache_inst_wr SHALL be 0, cache_inst_size 2'b10, cache_inst_wdata 0; cpu_inst_wr/size/wdata ignored.
REQ-023 Bus data_ok arriving outside REFILL SHALL be ignored.

Reset
REQ-024 resetn low SHALL asynchronously force IDLE, clear all valid and LRU bits, cnt, counters; all outputs 0 while low.
REQ-025 Reset mid-REFILL SHALL abandon the refill; first post-reset fetch misses.

Configuration
REQ-026 Macro ICACHE_STATS_EN defined: hit_cnt increments per IDLE hit handshake, miss_cnt per miss entry, both wrap at 2^32.
REQ-027 Macro ICACHE_STATS_EN undefined: counter logic absent, hit_cnt and miss_cnt tied to 0.

Verification
REQ-028 Cold fetch 0xBFC00008, LW=4 -> bus reads 0xBFC00000,04,08,0C in order; DONE returns word at 0xBFC00008; then fetch 0xBFC0000C hits same cycle.
REQ-029 Fetch A=0x00000000, B=0x00004000 (same set, OFFSET 4/INDEX 7), re-fetch A -> hit; fetch C=0x00008000 -> evicts B (LRU); B then misses, A still hits.
REQ-030 Bus addr_ok delayed 3 cycles and data_ok 5 cycles per word -> no duplicate requests, no cpu handshake before DONE.
REQ-031 resetn pulsed low during second refill word -> cache_inst_req drops immediately; refetch of same addr issues full LW-word refill.
REQ-032 With ICACHE_STATS_EN: sequence of REQ-029 -> hit_cnt=1 after A re-fetch, miss_cnt=3 after C; without macro both read 0.
